// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   SPI mode-0 master that reads one 32-bit word from a serial NOR flash with
//   the 03h READ command: 8-bit command, 24-bit address, then 32 data bits.
//   All fields are sent and received MSB first.
//
//   Parameters
//     CLK_DIV  clock cycles per sck half-period (>=1)
//     SS_GAP   minimum clock cycles ss stays high between transactions (>=1)
//
//   Ports
//     clock, resetn            system clock; asynchronous active-low reset
//     req_valid/req_ready      request handshake; req_addr is the byte address
//     resp_valid/resp_ready    response handshake; resp_data is the word read
//     sck, ss, mosi, miso      flash pins (sck idles low, ss active low)
//
//   Build option
//     FLASH_RD_BSWAP_EN  when defined, resp_data is the byte-swapped word, for
//                        a little-endian CPU fetch. Timing is the same either way.
module spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int SS_GAP  = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        sck,
    output logic        ss,
    output logic        mosi,
    input  logic        miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
    localparam logic [7:0] CMD_READ = 8'h03;

    typedef enum logic [2:0] {IDLE, CMDADDR, DATA, TAIL, RESP, GAP} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [5:0]       bit_cnt;
    logic [31:0]      shreg;
    logic             div_tc;

    assign div_tc = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Final word presentation; the shift register always holds the raw
    // bit stream with the first received bit in [31].
    function automatic logic [31:0] word_out(input logic [31:0] b);
`ifdef FLASH_RD_BSWAP_EN
        return {b[7:0], b[15:8], b[23:16], b[31:24]};
`else
        return b;
`endif
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            sck        <= 1'b0;
            ss         <= 1'b1;
            mosi       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        shreg     <= {CMD_READ, req_addr};
                        ss        <= 1'b0;
                        sck       <= 1'b0;
                        mosi      <= CMD_READ[7];
                        req_ready <= 1'b0;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        state     <= CMDADDR;
                    end
                end

                // Shift out command+address. mosi changes only on falling sck
                // so it is stable across every rising edge. The switch to DATA
                // happens on the fall after the 32nd rise, so the flash has
                // already sampled the last address bit when mosi drops to 0.
                CMDADDR: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (!sck) begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end else if (bit_cnt == 6'd32) begin
                            bit_cnt <= '0;
                            mosi    <= 1'b0;
                            state   <= DATA;
                        end else begin
                            shreg <= {shreg[30:0], 1'b0};
                            mosi  <= shreg[30];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                // miso is captured on the cycle that drives sck high; the
                // flash changed it on the previous falling edge.
                DATA: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (!sck) begin
                            shreg <= {shreg[30:0], miso};
                            if (bit_cnt == 6'd31) begin
                                bit_cnt <= '0;
                                state   <= TAIL;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                // Finish the last high half-period, hold sck low for one
                // cycle, then release ss together with the response.
                TAIL: begin
                    if (!sck) begin
                        ss         <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_data  <= word_out(shreg);
                        state      <= RESP;
                    end else if (div_tc) begin
                        div_cnt <= '0;
                        sck     <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= GAP;
                    end
                end

                // Keeps ss high long enough for the flash to reset its
                // command decoder before the next select.
                GAP: begin
                    if (gap_cnt == GAP_W'(SS_GAP - 1)) begin
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
